// File: rtl/census_cost_volume_if.sv
//------------------------------------------------------------------------------
// Module   : census_cost_volume_if
// Brief    : Census-pair input beat and cost-vector output handshake bundle.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface census_cost_volume_if #(
  parameter int CENSUS_W = 25,
  parameter int MAX_DISP = 64,
  parameter int COST_W   = $clog2(CENSUS_W + 1)
) ();

  logic [CENSUS_W-1:0]        census_l;
  logic [CENSUS_W-1:0]        census_r;
  logic                       in_valid;
  logic                       in_sol;
  logic                       in_ready;
  logic [MAX_DISP*COST_W-1:0] cost_out;
  logic                       out_valid;
  logic                       out_sol;
  logic                       out_ready;

  // Upstream producer plus downstream consumer side.
  modport master (
    output census_l, census_r, in_valid, in_sol, out_ready,
    input  in_ready, cost_out, out_valid, out_sol
  );

  modport slave (
    input  census_l, census_r, in_valid, in_sol, out_ready,
    output in_ready, cost_out, out_valid, out_sol
  );

endinterface

`default_nettype wire

// File: rtl/census_cost_volume.sv
//------------------------------------------------------------------------------
// Module   : census_cost_volume
// Brief    : Census Hamming cost per disparity with row masking and backpressure.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module census_cost_volume #(
  parameter int CENSUS_W = 25,
  parameter int MAX_DISP = 64,
  parameter int COST_W   = $clog2(CENSUS_W + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  census_cost_volume_if.slave  bus
);

  localparam int                 c_L       = (CENSUS_W <= 1) ? 0 : $clog2(CENSUS_W);
  localparam int                 c_COL_W   = $clog2(MAX_DISP + 1);
  localparam logic [c_COL_W-1:0] c_COL_MAX = c_COL_W'(MAX_DISP);

  // Operand count at a given adder-tree level.
  function automatic int f_ops(input int lvl);
    return (CENSUS_W + (1 << lvl) - 1) >> lvl;
  endfunction

  // Partner index of operand pair j, clamped so the select stays in range.
  function automatic int f_hi(input int j);
    return (2 * j + 1 < CENSUS_W) ? 2 * j + 1 : 2 * j;
  endfunction

  logic                              r_out_valid;
  logic                              r_out_sol;
  logic [MAX_DISP-1:0][COST_W-1:0]   r_cost;

  logic                              w_pe;

  assign w_pe         = bus.out_ready | ~r_out_valid;
  assign bus.in_ready = w_pe;

  //----------------------------------------------------------------------------
  // Stage 1: right window, left sample, column counter
  //----------------------------------------------------------------------------
  logic [CENSUS_W-1:0] r_win [MAX_DISP];
  logic [CENSUS_W-1:0] r_left;
  logic [c_COL_W-1:0]  r_col;
  logic                r_s1_v;
  logic                r_s1_sol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < MAX_DISP; d++) begin
        r_win[d] <= '0;
      end
      r_left   <= '0;
      r_col    <= '0;
      r_s1_v   <= 1'b0;
      r_s1_sol <= 1'b0;
    end else if (w_pe) begin
      r_s1_v   <= bus.in_valid;
      r_s1_sol <= bus.in_valid & bus.in_sol;
      if (bus.in_valid) begin
        r_win[0] <= bus.census_r;
        for (int d = 1; d < MAX_DISP; d++) begin
          r_win[d] <= r_win[d-1];
        end
        r_left <= bus.census_l;
        // Row start wins over saturation.
        if (bus.in_sol) begin
          r_col <= c_COL_W'(1);
        end else if (r_col != c_COL_MAX) begin
          r_col <= r_col + c_COL_W'(1);
        end
      end
    end
  end

  logic [MAX_DISP-1:0] w_m1;
  logic [COST_W-1:0]   w_x [MAX_DISP][CENSUS_W];

  always_comb begin
    for (int d = 0; d < MAX_DISP; d++) begin
      w_m1[d] = (d < int'(r_col));
      for (int b = 0; b < CENSUS_W; b++) begin
        w_x[d][b] = COST_W'(r_left[b] ^ r_win[d][b]);
      end
    end
  end

  //----------------------------------------------------------------------------
  // Popcount tree: level k registered holds f_ops(k) partial sums per lane
  //----------------------------------------------------------------------------
  logic [COST_W-1:0]   w_sum [MAX_DISP];
  logic [MAX_DISP-1:0] w_fm;
  logic                w_fv;
  logic                w_fs;

  if (c_L == 0) begin : g_direct
    always_comb begin
      for (int d = 0; d < MAX_DISP; d++) begin
        w_sum[d] = w_x[d][0];
      end
    end
    assign w_fm = w_m1;
    assign w_fv = r_s1_v;
    assign w_fs = r_s1_sol;
  end else begin : g_tree
    logic [COST_W-1:0]   r_lvl [c_L][MAX_DISP][CENSUS_W];
    logic [COST_W-1:0]   w_nxt [c_L][MAX_DISP][CENSUS_W];
    logic [MAX_DISP-1:0] r_lm  [c_L];
    logic [c_L-1:0]      r_lv;
    logic [c_L-1:0]      r_ls;

    always_comb begin
      for (int k = 0; k < c_L; k++) begin
        for (int d = 0; d < MAX_DISP; d++) begin
          for (int j = 0; j < CENSUS_W; j++) begin
            w_nxt[k][d][j] = '0;
          end
        end
      end
      for (int d = 0; d < MAX_DISP; d++) begin
        for (int b = 0; b < CENSUS_W; b++) begin
          w_nxt[0][d][b] = w_x[d][b];
        end
      end
      // An odd leftover operand passes through by adding zero.
      for (int k = 1; k < c_L; k++) begin
        for (int d = 0; d < MAX_DISP; d++) begin
          for (int j = 0; j < (CENSUS_W + 1) / 2; j++) begin
            if (j < f_ops(k)) begin
              w_nxt[k][d][j] = r_lvl[k-1][d][2*j]
                             + ((2 * j + 1 < f_ops(k - 1)) ? r_lvl[k-1][d][f_hi(j)] : '0);
            end
          end
        end
      end
      for (int d = 0; d < MAX_DISP; d++) begin
        w_sum[d] = r_lvl[c_L-1][d][0]
                 + ((f_ops(c_L - 1) > 1) ? r_lvl[c_L-1][d][1] : '0);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < c_L; k++) begin
          for (int d = 0; d < MAX_DISP; d++) begin
            for (int j = 0; j < CENSUS_W; j++) begin
              r_lvl[k][d][j] <= '0;
            end
          end
          r_lm[k] <= '0;
        end
        r_lv <= '0;
        r_ls <= '0;
      end else if (w_pe) begin
        r_lvl   <= w_nxt;
        r_lm[0] <= w_m1;
        r_lv[0] <= r_s1_v;
        r_ls[0] <= r_s1_sol;
        for (int k = 1; k < c_L; k++) begin
          r_lm[k] <= r_lm[k-1];
          r_lv[k] <= r_lv[k-1];
          r_ls[k] <= r_ls[k-1];
        end
      end
    end

    assign w_fm = r_lm[c_L-1];
    assign w_fv = r_lv[c_L-1];
    assign w_fs = r_ls[c_L-1];
  end

  //----------------------------------------------------------------------------
  // Output stage: masked lanes carry the all-ones "never select" marker
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cost      <= '0;
      r_out_valid <= 1'b0;
      r_out_sol   <= 1'b0;
    end else if (w_pe) begin
      for (int d = 0; d < MAX_DISP; d++) begin
        r_cost[d] <= w_fm[d] ? w_sum[d] : '1;
      end
      r_out_valid <= w_fv;
      r_out_sol   <= w_fs;
    end
  end

  assign bus.cost_out  = r_cost;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sol   = r_out_sol;

endmodule

`default_nettype wire
